// File: rtl/exu_div_ctl_pkg.sv
// ============================================================================
//  exu_div_ctl_pkg : request packet and helpers for the iterative divider
//  Rev 1.0
// ============================================================================
`default_nettype none

package exu_div_ctl_pkg;

    localparam int c_DIV_XLEN = 64;

    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
        logic word;
    } div_pkt_t;

    function automatic logic [c_DIV_XLEN-1:0] sext_word(input logic [31:0] v);
        return {{(c_DIV_XLEN-32){v[31]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/exu_div_ctl.sv
// ============================================================================
//  exu_div_ctl : iterative radix-2 divider for div/divu/rem/remu and W forms
//  Rev 1.0
// ============================================================================
`default_nettype none

module exu_div_ctl
    import exu_div_ctl_pkg::*;
#(
    parameter int XLEN  = c_DIV_XLEN,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  div_pkt_t        dp,
    input  logic            cancel,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            finish,
    output logic [XLEN-1:0] out
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARITH = 2'd1;
    localparam logic [1:0] c_FIX   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_q;
    logic [XLEN-1:0]  r_b_mag;
    logic [XLEN-1:0]  r_out;
    logic             r_finish;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_rem_op;
    logic             r_word;

    logic             w_accept;
    logic [XLEN-1:0]  w_a_ext;
    logic [XLEN-1:0]  w_b_ext;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [XLEN-1:0]  w_a_sext;
    logic             w_b_zero;
    logic             w_ovf;
    logic [XLEN-1:0]  w_spec_res;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_trial;
    logic             w_ge;
    logic [XLEN-1:0]  w_q_fix;
    logic [XLEN-1:0]  w_rem_fix;
    logic [XLEN-1:0]  w_res;
    logic [XLEN-1:0]  w_res_fin;

    assign w_accept = dp.valid & ~cancel & ~freeze &
                      ((r_state == c_IDLE) | (r_state == c_DONE));

    // Operand prep: word ops see only the low half, extended per signedness
    always_comb begin
        w_a_ext  = dividend;
        w_b_ext  = divisor;
        if (dp.word) begin
            w_a_ext = {{(XLEN-32){~dp.unsign & dividend[31]}}, dividend[31:0]};
            w_b_ext = {{(XLEN-32){~dp.unsign & divisor[31]}},  divisor[31:0]};
        end
        w_neg_a  = ~dp.unsign & w_a_ext[XLEN-1];
        w_neg_b  = ~dp.unsign & w_b_ext[XLEN-1];
        w_a_mag  = w_neg_a ? (XLEN'(0) - w_a_ext) : w_a_ext;
        w_b_mag  = w_neg_b ? (XLEN'(0) - w_b_ext) : w_b_ext;
        w_a_sext = dp.word ? sext_word(dividend[31:0]) : dividend;
        w_b_zero = (w_b_ext == '0);
        w_ovf    = ~dp.unsign &
                   (dp.word ? ((dividend[31:0] == 32'h8000_0000) && (&divisor[31:0]))
                            : ((dividend == {1'b1, {(XLEN-1){1'b0}}}) && (&divisor)));
        if (w_b_zero)
            w_spec_res = dp.rem ? w_a_sext : '1;
        else
            w_spec_res = dp.rem ? '0 : w_a_sext;
    end

    // Restoring step; the extra top bit keeps unsigned remainders >= 2^63 exact
    assign w_shift = {r_rem, r_q[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_b_mag};
    assign w_ge    = ~w_trial[XLEN];

    assign w_q_fix   = (r_neg_a ^ r_neg_b) ? (XLEN'(0) - r_q) : r_q;
    assign w_rem_fix = r_neg_a ? (XLEN'(0) - r_rem) : r_rem;
    assign w_res     = r_rem_op ? w_rem_fix : w_q_fix;
    assign w_res_fin = r_word ? sext_word(w_res[31:0]) : w_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_b_mag  <= '0;
            r_out    <= '0;
            r_finish <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_rem_op <= 1'b0;
            r_word   <= 1'b0;
        end else if (cancel) begin
            r_state  <= c_IDLE;
            r_finish <= 1'b0;
        end else if (!freeze) begin
            r_finish <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_rem_op <= dp.rem;
                        r_word   <= dp.word;
                        r_b_mag  <= w_b_mag;
                        if (w_b_zero || w_ovf) begin
                            r_state  <= c_DONE;
                            r_finish <= 1'b1;
                            r_out    <= w_spec_res;
                        end else begin
                            r_state <= c_ARITH;
                            r_cnt   <= dp.word ? CNT_W'(32) : CNT_W'(XLEN);
                            r_rem   <= '0;
                            // Word dividends sit in the top half so they shift out first
                            r_q     <= dp.word ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag;
                        end
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_ARITH: begin
                    r_rem <= w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1))
                        r_state <= c_FIX;
                end
                c_FIX: begin
                    r_out    <= w_res_fin;
                    r_state  <= c_DONE;
                    r_finish <= 1'b1;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == c_ARITH) || (r_state == c_FIX);
    assign finish = r_finish;
    assign out    = r_out;

    a_no_req_while_busy: assert property (@(posedge clk) disable iff (rst) !(dp.valid && busy));

endmodule

`default_nettype wire
